// File: rtl/exu_wb_arb.sv
// exu_wb_arb -- write-back arbiter for the execution units.
//
// Each of the four result sources (alu, mul, div, lsu) owns a one-entry
// holding buffer. Every cycle, the oldest valid buffer (by wrapping
// instruction tag) is granted. Its result is written to the register file
// through registered outputs one cycle later. Results for x0 still use their
// grant slot, but they never assert the write enable.
//
// Ports
//   clk, rstn                         clock, asynchronous active-low reset
//   <s>_valid/_rd_addr/_data/_tag     result offered by source s
//   <s>_ready                         result accepted this cycle (combinational)
//   exu_wb_rd_wr_en/_rd_addr/_data    registered register-file write port
//   exu_wb_stall                      two or more buffers currently occupied
module exu_wb_arb #(
  parameter int XLEN                = 32,
  parameter int REG_FILE_ADDR_WIDTH = 5,
  parameter int TAG_WIDTH           = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           alu_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] alu_rd_addr,
  input  logic [XLEN-1:0]                alu_data,
  input  logic [TAG_WIDTH-1:0]           alu_tag,
  output logic                           alu_ready,
  input  logic                           mul_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] mul_rd_addr,
  input  logic [XLEN-1:0]                mul_data,
  input  logic [TAG_WIDTH-1:0]           mul_tag,
  output logic                           mul_ready,
  input  logic                           div_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] div_rd_addr,
  input  logic [XLEN-1:0]                div_data,
  input  logic [TAG_WIDTH-1:0]           div_tag,
  output logic                           div_ready,
  input  logic                           lsu_valid,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] lsu_rd_addr,
  input  logic [XLEN-1:0]                lsu_data,
  input  logic [TAG_WIDTH-1:0]           lsu_tag,
  output logic                           lsu_ready,
  output logic                           exu_wb_rd_wr_en,
  output logic [REG_FILE_ADDR_WIDTH-1:0] exu_wb_rd_addr,
  output logic [XLEN-1:0]                exu_wb_data,
  output logic                           exu_wb_stall
);

  localparam int NSRC = 4;  // index order alu=0, mul=1, div=2, lsu=3

  // a is older than b when the wrapped difference a-b is "negative"
  function automatic logic is_older(input logic [TAG_WIDTH-1:0] a,
                                    input logic [TAG_WIDTH-1:0] b);
    logic [TAG_WIDTH-1:0] diff;
    diff = a - b;
    return diff[TAG_WIDTH-1];
  endfunction

  logic [NSRC-1:0]                in_valid_s;
  logic [REG_FILE_ADDR_WIDTH-1:0] in_rd_s   [NSRC];
  logic [XLEN-1:0]                in_data_s [NSRC];
  logic [TAG_WIDTH-1:0]           in_tag_s  [NSRC];

  logic [NSRC-1:0]                buf_valid_q, buf_valid_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] buf_rd_q   [NSRC];
  logic [REG_FILE_ADDR_WIDTH-1:0] buf_rd_d   [NSRC];
  logic [XLEN-1:0]                buf_data_q [NSRC];
  logic [XLEN-1:0]                buf_data_d [NSRC];
  logic [TAG_WIDTH-1:0]           buf_tag_q  [NSRC];
  logic [TAG_WIDTH-1:0]           buf_tag_d  [NSRC];

  logic [NSRC-1:0]                grant_s, ready_s, xfer_s;
  logic                           found_s, wins_s, any_grant_s;
  logic [REG_FILE_ADDR_WIDTH-1:0] gnt_rd_s;
  logic [XLEN-1:0]                gnt_data_s;

  logic                           wr_en_q, wr_en_d;
  logic [REG_FILE_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]                wb_data_q, wb_data_d;

  assign in_valid_s = {lsu_valid, div_valid, mul_valid, alu_valid};
  assign in_rd_s[0] = alu_rd_addr;  assign in_data_s[0] = alu_data;  assign in_tag_s[0] = alu_tag;
  assign in_rd_s[1] = mul_rd_addr;  assign in_data_s[1] = mul_data;  assign in_tag_s[1] = mul_tag;
  assign in_rd_s[2] = div_rd_addr;  assign in_data_s[2] = div_data;  assign in_tag_s[2] = div_tag;
  assign in_rd_s[3] = lsu_rd_addr;  assign in_data_s[3] = lsu_data;  assign in_tag_s[3] = lsu_tag;

  // Oldest-first selection. A buffer wins if it beats every other valid
  // buffer. Equal tags are broken by index, with the higher index winning.
  // The fallback only matters for tag sets that span more than half the tag
  // space. In that case, no total age order exists, and the fallback avoids
  // a deadlock.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    wins_s  = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      wins_s = buf_valid_q[i];
      for (int j = 0; j < NSRC; j++) begin
        if (j != i && buf_valid_q[j] &&
            !(is_older(buf_tag_q[i], buf_tag_q[j]) ||
              (buf_tag_q[i] == buf_tag_q[j] && i > j))) begin
          wins_s = 1'b0;
        end else begin
          wins_s = wins_s;
        end
      end
      if (wins_s && !found_s) begin
        grant_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        grant_s[i] = grant_s[i];
      end
    end
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (buf_valid_q[i] && !found_s) begin
        grant_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        grant_s[i] = grant_s[i];
      end
    end
  end

  // Payload of the granted buffer (one-hot mux)
  always_comb begin
    gnt_rd_s   = '0;
    gnt_data_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_s[i]) begin
        gnt_rd_s   = buf_rd_q[i];
        gnt_data_s = buf_data_q[i];
      end else begin
        gnt_rd_s   = gnt_rd_s;
        gnt_data_s = gnt_data_s;
      end
    end
  end

  assign any_grant_s = |grant_s;
  // A buffer that is being drained this cycle can accept a refill on the same edge
  assign ready_s     = ~buf_valid_q | grant_s;
  assign xfer_s      = in_valid_s & ready_s;

  // Buffer next state: refill wins over clear, otherwise hold
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      if (xfer_s[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_rd_d[i]    = in_rd_s[i];
        buf_data_d[i]  = in_data_s[i];
        buf_tag_d[i]   = in_tag_s[i];
      end else begin
        buf_valid_d[i] = buf_valid_q[i] & ~grant_s[i];
        buf_rd_d[i]    = buf_rd_q[i];
        buf_data_d[i]  = buf_data_q[i];
        buf_tag_d[i]   = buf_tag_q[i];
      end
    end
  end

  // Write port next state; x0 results consume the slot without writing
  always_comb begin
    if (any_grant_s) begin
      wr_en_d   = (gnt_rd_s != '0);
      wb_rd_d   = gnt_rd_s;
      wb_data_d = gnt_data_s;
    end else begin
      wr_en_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        buf_rd_q[i]   <= '0;
        buf_data_q[i] <= '0;
        buf_tag_q[i]  <= '0;
      end
      wr_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      for (int i = 0; i < NSRC; i++) begin
        buf_rd_q[i]   <= buf_rd_d[i];
        buf_data_q[i] <= buf_data_d[i];
        buf_tag_q[i]  <= buf_tag_d[i];
      end
      wr_en_q   <= wr_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign alu_ready       = ready_s[0];
  assign mul_ready       = ready_s[1];
  assign div_ready       = ready_s[2];
  assign lsu_ready       = ready_s[3];
  assign exu_wb_rd_wr_en = wr_en_q;
  assign exu_wb_rd_addr  = wb_rd_q;
  assign exu_wb_data     = wb_data_q;
  // Clearing the lowest set bit leaves something only if two or more are set
  assign exu_wb_stall    = ((buf_valid_q & (buf_valid_q - 4'd1)) != 4'd0);

endmodule

// File: doc/exu_wb_arb.md
EXU_WB_ARB -- requirements
Module: exu_wb_arb

Interface
REQ-001 Parameter XLEN, default 32, data width of write-back results.
REQ-002 Parameter REG_FILE_ADDR_WIDTH, default 5, destination register address width.
REQ-003 Parameter TAG_WIDTH, default 8, instruction tag width; tags wrap modulo 2^TAG_WIDTH.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk (in, 1, rising-edge clock) and rstn (in, 1, asynchronous active-low reset).
REQ-005 Each source S in {alu, mul, div, lsu} SHALL have the following ports:
- S_valid: in, 1, result offered.
- S_rd_addr: in, REG_FILE_ADDR_WIDTH, destination register.
- S_data: in, XLEN, result value.
- S_tag: in, TAG_WIDTH, instruction tag.
- S_ready: out, 1, result accepted this cycle.
REQ-006 exu_wb_rd_wr_en: out, 1, register-file write enable.
REQ-007 exu_wb_rd_addr: out, REG_FILE_ADDR_WIDTH, write address.
REQ-008 exu_wb_data: out, XLEN, write data.
REQ-009 exu_wb_stall: out, 1, write-back contention; ORed by the decode stage into its pipeline stall.

Function
REQ-010 Each source SHALL have a 1-entry holding buffer (valid, rd_addr, data, tag).
REQ-011 S_ready SHALL be combinational and equal ~buf_valid[S] | grant[S].
REQ-012 A transfer SHALL occur when S_valid & S_ready; the buffer SHALL load on that rising edge.
REQ-013 A source SHALL hold S_valid and its payload stable until S_ready is high; the block is not required to tolerate violations.
REQ-014 Each cycle, the block SHALL grant at most one valid buffer, namely the oldest by tag.
REQ-015 Age rule: A is older than B iff bit TAG_WIDTH-1 of (A.tag - B.tag) mod 2^TAG_WIDTH is 1; comparison SHALL be correct across tag wrap-around.
REQ-016 Equal tags SHALL never be presented simultaneously; if they are, priority SHALL be lsu > div > mul > alu.
REQ-017 The granted buffer SHALL clear on the next edge unless a new transfer refills it on the same edge; simultaneous grant and refill SHALL leave buf_valid=1 with the new payload.
REQ-018 Outputs exu_wb_* SHALL be registered: the grant made in cycle N SHALL appear on the outputs in cycle N+1 for exactly one cycle.
REQ-019 Minimum latency from S_valid&S_ready to exu_wb_rd_wr_en SHALL be 2 cycles.
REQ-020 When no buffer is valid, exu_wb_rd_wr_en SHALL be 0 in the next cycle; exu_wb_rd_addr and exu_wb_data SHALL hold their previous values.
REQ-021 A granted result with rd_addr==0 SHALL consume its grant slot but drive exu_wb_rd_wr_en=0 (x0 is never written).
REQ-022 exu_wb_stall SHALL be combinational and equal 1 iff two or more buffers are valid in the current cycle.
REQ-023 Sustained throughput SHALL be one write-back per cycle.
REQ-024 No buffered result SHALL be lost or duplicated under any interleaving.
REQ-025 Pipeline flush SHALL NOT affect this block; all buffered results belong to already-executed instructions and SHALL commit.

Reset
REQ-026 While rstn=0, all buf_valid SHALL be 0.
REQ-027 While rstn=0, exu_wb_rd_wr_en=0, exu_wb_rd_addr=0, exu_wb_data=0 and exu_wb_stall=0.
REQ-028 While rstn=0, every S_ready SHALL be 1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered results immediately without producing a write.
REQ-030 Normal operation SHALL resume on the first rising edge after rstn deasserts.

Verification
REQ-031 Single ALU result: alu_valid=1, rd=5, data=0x1234, tag=3 at cycle 0 -> wr_en=1, rd=5, data=0x1234 at cycle 2 only; alu_ready stays 1.
REQ-032 Contention: mul (tag=10, rd=7) and alu (tag=11, rd=7) accepted in the same cycle -> mul writes in cycle 2, alu in cycle 3, final x7 = alu data; exu_wb_stall=1 in cycle 1.
REQ-033 Wrap-around: div tag=0xFE and lsu tag=0x01 are both buffered -> div is granted first; lsu follows next cycle.
REQ-034 x0 write: lsu rd=0, data=0xDEAD -> exu_wb_rd_wr_en stays 0; the slot is consumed; lsu_ready returns to 1.
REQ-035 Back-to-back and refill: alu valid every cycle for 8 cycles with tags 0..7 -> 8 consecutive writes in tag order, alu_ready constantly 1, no gaps.
REQ-036 Reset mid-flight: three buffers valid, rstn=0 for one cycle -> no write-back occurs; all ready=1; the next post-reset result completes with 2-cycle latency.
